// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: one single-beat read or write in flight, result returned on a valid/ready response port.
// Optional response watchdog: define AXI4_LITE_MASTER_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).

module axi4_lite_master #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int REG_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      axi4_lite_aclk,
   input  logic                      axi4_lite_areset,
   // local command / response port
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
   input  logic [REG_DATA_WIDTH-1:0] cmd_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [REG_DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]                rsp_resp,
   // write address / data / response channels
   output logic [ADDRESS_WIDTH-1:0]  axi4_lite_awaddr,
   output logic                      axi4_lite_awvalid,
   input  logic                      axi4_lite_awready,
   output logic [REG_DATA_WIDTH-1:0] axi4_lite_wdata,
   output logic                      axi4_lite_wvalid,
   input  logic                      axi4_lite_wready,
   input  logic [1:0]                axi4_lite_bresp,
   input  logic                      axi4_lite_bvalid,
   output logic                      axi4_lite_bready,
   // read address / data channels
   output logic [ADDRESS_WIDTH-1:0]  axi4_lite_araddr,
   output logic                      axi4_lite_arvalid,
   input  logic                      axi4_lite_arready,
   input  logic [REG_DATA_WIDTH-1:0] axi4_lite_rdata,
   input  logic [1:0]                axi4_lite_rresp,
   input  logic                      axi4_lite_rvalid,
   output logic                      axi4_lite_rready
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } state_t;

   localparam logic [1:0] RESP_SLVERR = 2'b10;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t                    state_q, state_d;
   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q, wvalid_d;
   logic                      bready_q, bready_d;
   logic                      arvalid_q, arvalid_d;
   logic                      rready_q, rready_d;
   logic [ADDRESS_WIDTH-1:0]  awaddr_q, awaddr_d;
   logic [ADDRESS_WIDTH-1:0]  araddr_q, araddr_d;
   logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      rsp_write_q, rsp_write_d;
   logic [REG_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                rsp_resp_q, rsp_resp_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic aw_done, w_done;
   logic wr_end, rd_end, progress, expired;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
   localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   assign cmd_ready = (state_q == IDLE);

   always_comb begin
      // NOTE: every signal written here gets a default first, otherwise the paths that skip it infer latches.
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      awaddr_d    = awaddr_q;
      araddr_d    = araddr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      wr_end      = 1'b0;
      rd_end      = 1'b0;
      progress    = 1'b0;

      aw_hs   = awvalid_q & axi4_lite_awready;
      w_hs    = wvalid_q  & axi4_lite_wready;
      b_hs    = bready_q  & axi4_lite_bvalid;
      ar_hs   = arvalid_q & axi4_lite_arready;
      r_hs    = rready_q  & axi4_lite_rvalid;
      aw_done = ~awvalid_q | axi4_lite_awready;
      w_done  = ~wvalid_q  | axi4_lite_wready;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_write) begin
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  bready_d  = 1'b1;
                  state_d   = WR_ADDR;
               end else begin
                  araddr_d  = cmd_addr;
                  arvalid_d = 1'b1;
                  rready_d  = 1'b1;
                  state_d   = RD_ADDR;
               end
            end
         end
         WR_ADDR: begin
            progress = aw_hs | w_hs;
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            // a B beat only counts once both AW and W have been accepted
            if (aw_done && w_done) begin
               if (b_hs) begin
                  progress = 1'b1;
                  wr_end   = 1'b1;
               end else begin
                  state_d = WR_RESP;
               end
            end
         end
         WR_RESP: begin
            progress = b_hs;
            wr_end   = b_hs;
         end
         RD_ADDR: begin
            progress = ar_hs;
            if (ar_hs) begin
               arvalid_d = 1'b0;
               if (r_hs) rd_end = 1'b1;
               else      state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            progress = r_hs;
            rd_end   = r_hs;
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      cnt_d   = cnt_q;
      expired = 1'b0;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q != RSP) begin
         expired = (cnt_q == CNT_LIMIT);
         // saturate so a handshake at expiry does not wrap the watchdog
         if (!expired) cnt_d = cnt_q + 1'b1;
      end
`else
      expired = 1'b0;
`endif

      if (wr_end) begin
         bready_d    = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_write_d = 1'b1;
         rsp_rdata_d = '0;
         rsp_resp_d  = axi4_lite_bresp;
         state_d     = RSP;
      end else if (rd_end) begin
         rready_d    = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_write_d = 1'b0;
         rsp_rdata_d = axi4_lite_rdata;
         rsp_resp_d  = axi4_lite_rresp;
         state_d     = RSP;
      end else if (expired && !progress) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_write_d = (state_q == WR_ADDR) || (state_q == WR_RESP);
         rsp_rdata_d = '0;
         rsp_resp_d  = RESP_SLVERR;
         state_d     = RSP;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge axi4_lite_aclk) begin
      if (axi4_lite_areset) begin
         state_q     <= IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign axi4_lite_awaddr  = awaddr_q;
   assign axi4_lite_awvalid = awvalid_q;
   assign axi4_lite_wdata   = wdata_q;
   assign axi4_lite_wvalid  = wvalid_q;
   assign axi4_lite_bready  = bready_q;
   assign axi4_lite_araddr  = araddr_q;
   assign axi4_lite_arvalid = arvalid_q;
   assign axi4_lite_rready  = rready_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_write         = rsp_write_q;
   assign rsp_rdata         = rsp_rdata_q;
   assign rsp_resp          = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with a small behavioural AXI4-Lite responder.
// The watchdog scenario runs only when AXI4_LITE_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).

module tb_axi4_lite_master;

   logic        clk = 1'b0;
   logic        areset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   axi4_lite_master #(
      .ADDRESS_WIDTH (32),
      .REG_DATA_WIDTH(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .axi4_lite_aclk   (clk),
      .axi4_lite_areset (areset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_write        (cmd_write),
      .cmd_addr         (cmd_addr),
      .cmd_wdata        (cmd_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_write        (rsp_write),
      .rsp_rdata        (rsp_rdata),
      .rsp_resp         (rsp_resp),
      .axi4_lite_awaddr (awaddr),
      .axi4_lite_awvalid(awvalid),
      .axi4_lite_awready(awready),
      .axi4_lite_wdata  (wdata),
      .axi4_lite_wvalid (wvalid),
      .axi4_lite_wready (wready),
      .axi4_lite_bresp  (bresp),
      .axi4_lite_bvalid (bvalid),
      .axi4_lite_bready (bready),
      .axi4_lite_araddr (araddr),
      .axi4_lite_arvalid(arvalid),
      .axi4_lite_arready(arready),
      .axi4_lite_rdata  (rdata),
      .axi4_lite_rresp  (rresp),
      .axi4_lite_rvalid (rvalid),
      .axi4_lite_rready (rready)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // responder knobs and state; it reacts on the falling edge so the master samples stable inputs
   int          aw_delay   = 0;
   logic [1:0]  bresp_knob = 2'b00;
   bit          ar_block   = 1'b0;
   bit          r_hold     = 1'b0;
   int          aw_wait    = 0;
   bit          aw_got, w_got, ar_got;
   logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
   logic [31:0] mem [logic [31:0]];

   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
      aw_addr_l = '0; w_data_l = '0; ar_addr_l = '0;
   end

   always @(negedge clk) begin
      if (areset) begin
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
         aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; aw_wait = 0;
      end else begin
         // bready/rready are held by the master while it waits, so a pulse is always consumed
         if (bvalid) bvalid = 1'b0;
         else if (aw_got && w_got) begin
            mem[aw_addr_l] = w_data_l;
            bresp  = bresp_knob;
            bvalid = 1'b1;
            aw_got = 1'b0;
            w_got  = 1'b0;
         end
         if (rvalid) rvalid = 1'b0;
         else if (ar_got && !r_hold) begin
            rdata  = mem.exists(ar_addr_l) ? mem[ar_addr_l] : 32'h0;
            rresp  = 2'b00;
            rvalid = 1'b1;
            ar_got = 1'b0;
         end
         awready = 1'b0;
         if (awvalid) begin
            if (aw_wait >= aw_delay) begin
               awready = 1'b1; aw_got = 1'b1; aw_addr_l = awaddr; aw_wait = 0;
            end else begin
               aw_wait++;
            end
         end
         wready = 1'b1;
         if (wvalid) begin
            w_got = 1'b1; w_data_l = wdata;
         end
         arready = 1'b0;
         if (arvalid && !ar_block) begin
            arready = 1'b1; ar_got = 1'b1; ar_addr_l = araddr;
         end
      end
   end

   int rsp_count = 0;
   always @(posedge clk) begin
      if (!areset && rsp_valid && rsp_ready) rsp_count++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // returns at the sample point of the first cycle after the command handshake
   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data);
      int n;
      n = 0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      check("issue_cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int cycles);
      int n;
      n = 0;
      while (!rsp_valid && n < 100) begin
         tick();
         n++;
      end
      cycles = n;
      check("rsp_seen", rsp_valid, 1);
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=hang exp=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int cyc, base, aw_cnt, w_cnt;
      bit addr_stable;
      logic [34:0] saved;

      areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
      tick();
      tick();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
      check("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 36'h0);
      check("rst_addr_data", {awaddr, araddr, wdata}, 96'h0);
      areset = 1'b0;
      tick();

      // plain write, responder ready on both channels
      issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      check("t1_aw_w_valid", {awvalid, wvalid, bready, arvalid}, 4'b1110);
      check("t1_awaddr", awaddr, 32'h0000_0010);
      check("t1_wdata", wdata, 32'hDEAD_BEEF);
      wait_rsp(cyc);
      check("t1_latency", cyc, 2);
      check("t1_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
      base = rsp_count;
      take_rsp();
      check("t1_rsp_drop", rsp_valid, 0);
      check("t1_rsp_count", rsp_count - base, 1);

      // read back
      issue(1'b0, 32'h0000_0010, 32'h0);
      check("t2_ar_valid", {arvalid, rready, awvalid}, 3'b110);
      check("t2_araddr", araddr, 32'h0000_0010);
      wait_rsp(cyc);
      check("t2_latency", cyc, 2);
      check("t2_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'hDEAD_BEEF});
      take_rsp();

      // error response on write
      bresp_knob = 2'b11;
      issue(1'b1, 32'h0001_0000, 32'h0BAD_F00D);
      wait_rsp(cyc);
      check("t3_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b11, 32'h0});
      take_rsp();
      bresp_knob = 2'b00;

      // awready held low three cycles, wready high
      aw_delay = 3;
      base = rsp_count;
      issue(1'b1, 32'h0000_0040, 32'hCAFE_0004);
      aw_cnt = 0; w_cnt = 0; addr_stable = 1'b1; cyc = 0;
      while (!rsp_valid && cyc < 50) begin
         if (awvalid) begin
            aw_cnt++;
            if (awaddr !== 32'h0000_0040) addr_stable = 1'b0;
         end
         if (wvalid) w_cnt++;
         tick();
         cyc++;
      end
      check("t4_awvalid_cycles", aw_cnt, 4);
      check("t4_wvalid_cycles", w_cnt, 1);
      check("t4_awaddr_stable", addr_stable, 1);
      check("t4_rsp", {rsp_valid, rsp_write, rsp_resp}, {1'b1, 1'b1, 2'b00});
      take_rsp();
      tick(); tick(); tick();
      check("t4_one_rsp", rsp_count - base, 1);
      aw_delay = 0;

      // response back-pressure with a pending command
      issue(1'b1, 32'h0000_0020, 32'h1234_5678);
      wait_rsp(cyc);
      saved = {rsp_write, rsp_resp, rsp_rdata};
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0020;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_hold_valid", rsp_valid, 1);
         check("t5_hold_fields", {rsp_write, rsp_resp, rsp_rdata}, saved);
         check("t5_cmd_blocked", {cmd_ready, arvalid}, 2'b00);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t5_after_rsp", {rsp_valid, cmd_ready, arvalid}, 3'b010);
      tick();
      cmd_valid = 1'b0;
      check("t5_second_accept", {cmd_ready, arvalid, araddr}, {2'b01, 32'h0000_0020});
      wait_rsp(cyc);
      check("t5_read_back", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h1234_5678});
      take_rsp();

      // reset while waiting for R
      r_hold = 1'b1;
      base = rsp_count;
      issue(1'b0, 32'h0000_0010, 32'h0);
      tick();
      check("t6_in_rd_resp", {arvalid, rready}, 2'b01);
      areset = 1'b1;
      tick();
      check("t6_rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
      check("t6_rst_cmd_ready", cmd_ready, 1);
      areset = 1'b0;
      r_hold = 1'b0;
      tick(); tick(); tick();
      check("t6_no_rsp", {rsp_valid, 32'(rsp_count - base)}, 33'h0);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      // read address never accepted: watchdog fires after TIMEOUT_CYCLES=8 cycles
      ar_block = 1'b1;
      issue(1'b0, 32'h0000_0080, 32'h0);
      cyc = 0;
      while (arvalid && cyc < 50) begin
         cyc++;
         tick();
      end
      check("t7_arvalid_cycles", cyc, 8);
      check("t7_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b10, 32'h0});
      check("t7_readies", {rready, bready}, 2'b00);
      take_rsp();
      ar_block = 1'b0;
`endif

      // recovery: read the word written with the error response
      issue(1'b0, 32'h0001_0000, 32'h0);
      wait_rsp(cyc);
      check("t8_read", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h0BAD_F00D});
      take_rsp();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

AXI4-Lite initiator that turns single-beat commands from local control logic into AXI4-Lite read or write transactions. It drives the address, data and response channels toward an `axi4_lite_slave`-class responder. It returns read data and response codes through a valid/ready response port. One transaction is in flight at a time, and no outstanding or pipelined requests are issued.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, AXI address width.
- REG_DATA_WIDTH, 32, AXI data width.
- TIMEOUT_CYCLES, 256, response watchdog limit; used only with AXI4_LITE_MASTER_TIMEOUT_EN; must be ≥2.

Ports:
- axi4_lite_aclk  in  1  clock; all logic on rising edge.
- axi4_lite_areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted (high only in IDLE).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_WIDTH  target address.
- cmd_wdata  in  REG_DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  REG_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP/RRESP, or 2'b10 on timeout.
- axi4_lite_awaddr / awvalid / awready  out/out/in  ADDRESS_WIDTH/1/1  write address channel.
- axi4_lite_wdata / wvalid / wready  out/out/in  REG_DATA_WIDTH/1/1  write data channel.
- axi4_lite_bresp / bvalid / bready  in/in/out  2/1/1  write response channel.
- axi4_lite_araddr / arvalid / arready  out/out/in  ADDRESS_WIDTH/1/1  read address channel.
- axi4_lite_rdata / rresp / rvalid / rready  in/in/in/out  REG_DATA_WIDTH/2/1/1  read data channel.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - WR_ADDR: awvalid and/or wvalid are outstanding.
  - WR_RESP: waiting for bvalid.
  - RD_ADDR: arvalid outstanding.
  - RD_RESP: waiting for rvalid.
  - RSP: rsp_valid=1.
- IDLE, on cmd_valid&cmd_ready: latch addr and wdata. Go to WR_ADDR with awvalid=wvalid=1, or to RD_ADDR with arvalid=1.
- WR_ADDR: awvalid and wvalid drop independently on their own handshake. When both channels are complete, go to WR_RESP. If both complete in the same cycle, go to WR_RESP directly.
- bready=1 throughout WR_ADDR and WR_RESP, because the responder may pulse bvalid for only one cycle.
  - A B handshake ends the write in either state. BRESP is captured and the FSM goes to RSP.
  - A bvalid arriving before both AW and W complete is a protocol error. It is ignored.
- RD_ADDR: arvalid is held until arready. rready=1 in RD_ADDR and RD_RESP.
  - An R handshake captures rdata and rresp and goes to RSP.
  - If R arrives in the same cycle as the AR handshake, the FSM goes to RSP directly.
- RSP: rsp_valid is held and the outputs stay stable until rsp_ready. The FSM then returns to IDLE. A new command can be accepted one cycle later at the earliest.
- AXI valids never drop before their handshake. Addresses and data stay stable while valid is high.
- Commands presented outside IDLE are not accepted, because cmd_ready=0.

## Timing
- Reset values (the cycle after axi4_lite_areset is sampled high):
  - state=IDLE, cmd_ready=1.
  - All AXI valid outputs 0, bready=0, rready=0.
  - rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_write=0.
  - awaddr=araddr=wdata=0.
- Reset mid-transaction abandons the transfer: all valids drop at that edge and no response is produced.
- Minimum write, with the responder ready: cmd handshake at edge N, AW/W valid in cycle N+1, B captured at N+2 or later, rsp_valid from N+3.
- Minimum read: cmd at edge N, arvalid in cycle N+1, rsp_valid one cycle after the R handshake.
- All outputs are registered except cmd_ready, which decodes state directly.

## Configuration
- AXI4_LITE_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to WR_ADDR or RD_ADDR and increments each cycle until the transaction ends.
  - When it reaches TIMEOUT_CYCLES-1, all AXI valids and readies drop. The FSM enters RSP with rsp_resp=2'b10 and rsp_rdata=0.
  - A handshake in the same cycle as expiry takes priority, and no timeout is reported.
- Macro undefined: no counter is built, and the master waits indefinitely.

## Test plan
- Write 0x0000_0010 with data 0xDEAD_BEEF, responder always ready: awvalid and wvalid asserted the same cycle. rsp_valid with rsp_write=1, rsp_resp=2'b00.
- Read back 0x0000_0010: rsp_rdata=0xDEAD_BEEF, rsp_resp=2'b00, rsp_write=0.
- Write to 0x0001_0000, responder returns BRESP=2'b11: rsp_resp=2'b11.
- Responder holds awready=0 for 3 cycles while wready=1: wvalid drops after 1 cycle, awvalid is held 4 cycles with awaddr stable, and exactly one response is produced.
- Hold rsp_ready=0 for 5 cycles while cmd_valid=1: rsp outputs stay stable, cmd_ready=0, and the second command is accepted only after the rsp handshake.
- With the macro defined and TIMEOUT_CYCLES=8, send a read to a responder with arready tied 0: arvalid drops after 8 cycles and rsp_resp=2'b10. Also assert reset during RD_RESP: no rsp_valid, and all valids are 0 next cycle.
